// File: rtl/sap_microsequencer_if.sv
// sap_microsequencer_if: bundles the sequencer's control-side signals.
//   advance   : stage-advance enable (hold high to run, pulse to single-step)
//   opcode    : instruction register opcode field (OPW bits)
//   zero_flag : ALU zero result, only consumed when JZ support is built in
//   ctrl      : 15-bit datapath control word
//   stage     : current state code (0-5 = T0-T5, 6 = RESET, 7 = HALT)
//   halted    : high while in HALT
//   fetch     : high while in T0
// master = the CPU side driving the sequencer, slave = the sequencer.
interface sap_microsequencer_if #(
    parameter int unsigned OPW = 4
);
    logic           advance;
    logic [OPW-1:0] opcode;
    logic           zero_flag;
    logic [14:0]    ctrl;
    logic [2:0]     stage;
    logic           halted;
    logic           fetch;

    modport master (
        output advance, opcode, zero_flag,
        input  ctrl, stage, halted, fetch
    );

    modport slave (
        input  advance, opcode, zero_flag,
        output ctrl, stage, halted, fetch
    );
endinterface

// File: rtl/sap_microsequencer.sv
// sap_microsequencer: microcoded fetch/execute sequencer for the 8-bit SAP CPU.
// Steps RESET -> T0..T5 -> T0 (ending each instruction after its last
// micro-op) and parks in HALT after an HLT until reset.
// Ports:
//   clk   : clock; stage advances on posedge, ctrl is registered on negedge
//   rst_n : synchronous active-low reset
//   bus   : sap_microsequencer_if.slave (advance, opcode, zero_flag in;
//           ctrl, stage, halted, fetch out)
// Build option: define SEQ_JZ_EN to decode opcode 0x8 as JZ (jump when
// zero_flag is set); otherwise 0x8 executes as NOP.
module sap_microsequencer #(
    parameter int unsigned OPW       = 4,
    parameter logic [14:0] CTRL_IDLE = 15'h0FE3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sap_microsequencer_if.slave   bus
);

    // Control word bit positions
    localparam int unsigned CB_PC_INC         = 14;
    localparam int unsigned CB_PC_EN          = 13;
    localparam int unsigned CB_PC_LOAD        = 12;
    localparam int unsigned CB_MAR_ADDR_LOAD_N = 11;
    localparam int unsigned CB_RAM_EN_N       = 9;
    localparam int unsigned CB_RAM_LOAD_N     = 8;
    localparam int unsigned CB_IR_LOAD_N      = 7;
    localparam int unsigned CB_IR_EN_N        = 6;
    localparam int unsigned CB_REGA_LOAD_N    = 5;
    localparam int unsigned CB_REGA_EN        = 4;
    localparam int unsigned CB_ADDER_SUB      = 3;
    localparam int unsigned CB_REGB_EN        = 2;
    localparam int unsigned CB_REGB_LOAD_N    = 1;
    localparam int unsigned CB_OUT_LOAD_N     = 0;

    localparam logic [OPW-1:0] OP_HLT = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(3);
    localparam logic [OPW-1:0] OP_LDA = OPW'(4);
    localparam logic [OPW-1:0] OP_OUT = OPW'(5);
    localparam logic [OPW-1:0] OP_STA = OPW'(6);
    localparam logic [OPW-1:0] OP_JMP = OPW'(7);
`ifdef SEQ_JZ_EN
    localparam logic [OPW-1:0] OP_JZ  = OPW'(8);
`endif

    typedef enum logic [2:0] {
        S_T0    = 3'd0,
        S_T1    = 3'd1,
        S_T2    = 3'd2,
        S_T3    = 3'd3,
        S_T4    = 3'd4,
        S_T5    = 3'd5,
        S_RESET = 3'd6,
        S_HALT  = 3'd7
    } state_e;

    state_e         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic           halted_q, halted_d;
    logic           fetch_q, fetch_d;
    logic [14:0]    ctrl_q, ctrl_d;

    logic [OPW-1:0] opcode_in;
    logic           advance_in;
    logic           zero_in;
    logic           op_has_t4;
    logic           op_has_t5;

    assign opcode_in  = bus.opcode;
    assign advance_in = bus.advance;

`ifdef SEQ_JZ_EN
    assign zero_in = bus.zero_flag;
`else
    logic unused_zero_flag;
    assign unused_zero_flag = bus.zero_flag;
    assign zero_in          = 1'b0;
`endif

    // Instruction length from the latched opcode: memory ops run to T4, ALU ops to T5
    assign op_has_t5 = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign op_has_t4 = op_has_t5 || (op_q == OP_LDA) || (op_q == OP_STA);

    // Next-state logic; opcode is captured on the T2->T3 edge only
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_RESET: if (advance_in) state_d = S_T0;
            S_T0:    if (advance_in) state_d = S_T1;
            S_T1:    if (advance_in) state_d = S_T2;
            S_T2: begin
                if (advance_in) begin
                    state_d = S_T3;
                    op_d    = opcode_in;
                end
            end
            S_T3: begin
                if (advance_in) begin
                    if (op_q == OP_HLT)  state_d = S_HALT;
                    else if (op_has_t4)  state_d = S_T4;
                    else                 state_d = S_T0;
                end
            end
            S_T4: begin
                if (advance_in) state_d = op_has_t5 ? S_T5 : S_T0;
            end
            S_T5:    if (advance_in) state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
        halted_d = (state_d == S_HALT);
        fetch_d  = (state_d == S_T0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_RESET;
            op_q     <= '0;
            halted_q <= 1'b0;
            fetch_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            halted_q <= halted_d;
            fetch_q  <= fetch_d;
        end
    end

    // Microcode decode: start from the idle word and flip only the active pins
    always_comb begin
        ctrl_d = CTRL_IDLE;
        case (state_q)
            S_T0: begin
                ctrl_d[CB_PC_EN]           = 1'b1;
                ctrl_d[CB_MAR_ADDR_LOAD_N] = 1'b0;
            end
            S_T1: begin
                ctrl_d[CB_PC_INC] = 1'b1;
            end
            S_T2: begin
                ctrl_d[CB_RAM_EN_N]  = 1'b0;
                ctrl_d[CB_IR_LOAD_N] = 1'b0;
            end
            S_T3: begin
                if (op_has_t4) begin
                    ctrl_d[CB_IR_EN_N]         = 1'b0;
                    ctrl_d[CB_MAR_ADDR_LOAD_N] = 1'b0;
                end else if (op_q == OP_OUT) begin
                    ctrl_d[CB_REGA_EN]    = 1'b1;
                    ctrl_d[CB_OUT_LOAD_N] = 1'b0;
                end else if (op_q == OP_JMP) begin
                    ctrl_d[CB_IR_EN_N]  = 1'b0;
                    ctrl_d[CB_PC_LOAD]  = 1'b1;
                end
`ifdef SEQ_JZ_EN
                else if ((op_q == OP_JZ) && zero_in) begin
                    ctrl_d[CB_IR_EN_N]  = 1'b0;
                    ctrl_d[CB_PC_LOAD]  = 1'b1;
                end
`endif
            end
            S_T4: begin
                if (op_q == OP_LDA) begin
                    ctrl_d[CB_RAM_EN_N]    = 1'b0;
                    ctrl_d[CB_REGA_LOAD_N] = 1'b0;
                end else if (op_has_t5) begin
                    ctrl_d[CB_RAM_EN_N]    = 1'b0;
                    ctrl_d[CB_REGB_LOAD_N] = 1'b0;
                    ctrl_d[CB_ADDER_SUB]   = (op_q == OP_SUB);
                end else if (op_q == OP_STA) begin
                    ctrl_d[CB_REGA_EN]    = 1'b1;
                    ctrl_d[CB_RAM_LOAD_N] = 1'b0;
                end
            end
            S_T5: begin
                if (op_has_t5) begin
                    ctrl_d[CB_REGB_EN]     = 1'b1;
                    ctrl_d[CB_REGA_LOAD_N] = 1'b0;
                    ctrl_d[CB_ADDER_SUB]   = (op_q == OP_SUB);
                end
            end
            default: ctrl_d = CTRL_IDLE;
        endcase
        // zero_in only matters for JZ; keep it referenced in every build
        if (zero_in && (state_q == S_HALT)) ctrl_d = CTRL_IDLE;
    end

    // Control word register on the falling edge so it is settled at the next posedge
    always_ff @(negedge clk) begin
        if (!rst_n) ctrl_q <= CTRL_IDLE;
        else        ctrl_q <= ctrl_d;
    end

    assign bus.ctrl   = ctrl_q;
    assign bus.stage  = 3'(state_q);
    assign bus.halted = halted_q;
    assign bus.fetch  = fetch_q;

endmodule

// File: tb/tb_sap_microsequencer.sv
// Directed testbench for sap_microsequencer. Observes the stage/ctrl pair
// 1 time unit after each negedge, where ctrl reflects the current stage.
module tb_sap_microsequencer;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;

`ifdef SEQ_JZ_EN
    localparam logic [14:0] JZ_TAKEN = 15'h1FA3;
`else
    localparam logic [14:0] JZ_TAKEN = 15'h0FE3;
`endif

    sap_microsequencer_if #(.OPW(4)) bus ();

    sap_microsequencer #(.OPW(4), .CTRL_IDLE(15'h0FE3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.advance    = 1'b1;
        bus.opcode     = 4'h1;
        bus.zero_flag  = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (bus.stage !== 3'd6 || bus.ctrl !== 15'h0FE3 || bus.halted !== 1'b0 || bus.fetch !== 1'b0) begin
            n_mis++;
            $display("FAIL reset: stage=%0d ctrl=%h halted=%b fetch=%b, want 6 0fe3 0 0",
                     bus.stage, bus.ctrl, bus.halted, bus.fetch);
        end
        rst_n       = 1'b1;
        bus.advance = 1'b0;
        tick();
        n_cmp++;
        if (bus.stage !== 3'd6 || bus.ctrl !== 15'h0FE3) begin
            n_mis++;
            $display("FAIL reset_hold: stage=%0d ctrl=%h, want 6 0fe3", bus.stage, bus.ctrl);
        end
        bus.advance = 1'b1;
        tick();
        n_cmp++;
        if (bus.stage !== 3'd0 || bus.ctrl !== 15'h27E3 || bus.fetch !== 1'b1) begin
            n_mis++;
            $display("FAIL first_t0: stage=%0d ctrl=%h fetch=%b, want 0 27e3 1",
                     bus.stage, bus.ctrl, bus.fetch);
        end
    endtask

    task automatic test_lda();
        int unsigned es[5] = '{1, 2, 3, 4, 0};
        logic [14:0] ec[5] = '{15'h4FE3, 15'h0D63, 15'h07A3, 15'h0DC3, 15'h27E3};
        bus.opcode = 4'h4;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (bus.stage !== 3'(es[i]) || bus.ctrl !== ec[i]) begin
                n_mis++;
                $display("FAIL lda[%0d]: stage=%0d ctrl=%h, want %0d %h",
                         i, bus.stage, bus.ctrl, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_add_sub();
        int unsigned es[6]  = '{1, 2, 3, 4, 5, 0};
        logic [14:0] sub[6] = '{15'h4FE3, 15'h0D63, 15'h07A3, 15'h0DE9, 15'h0FCF, 15'h27E3};
        logic [14:0] add[6] = '{15'h4FE3, 15'h0D63, 15'h07A3, 15'h0DE1, 15'h0FC7, 15'h27E3};
        bus.opcode = 4'h3;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (bus.stage !== 3'(es[i]) || bus.ctrl !== sub[i]) begin
                n_mis++;
                $display("FAIL sub[%0d]: stage=%0d ctrl=%h, want %0d %h",
                         i, bus.stage, bus.ctrl, es[i], sub[i]);
            end
        end
        bus.opcode = 4'h2;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++;
            if (bus.stage !== 3'(es[i]) || bus.ctrl !== add[i]) begin
                n_mis++;
                $display("FAIL add[%0d]: stage=%0d ctrl=%h, want %0d %h",
                         i, bus.stage, bus.ctrl, es[i], add[i]);
            end
        end
    endtask

    // Short and store instructions: T3 word (and T4 for STA), then back to T0
    task automatic test_short_ops();
        logic [3:0]  ops[5] = '{4'h6, 4'h5, 4'h7, 4'h1, 4'hF};
        logic [14:0] t3[5]  = '{15'h07A3, 15'h0FF2, 15'h1FA3, 15'h0FE3, 15'h0FE3};
        for (int k = 0; k < 5; k++) begin
            bus.opcode = ops[k];
            tick();
            tick();
            tick();
            n_cmp++;
            if (bus.stage !== 3'd3 || bus.ctrl !== t3[k]) begin
                n_mis++;
                $display("FAIL op%h_t3: stage=%0d ctrl=%h, want 3 %h",
                         ops[k], bus.stage, bus.ctrl, t3[k]);
            end
            if (ops[k] == 4'h6) begin
                tick();
                n_cmp++;
                if (bus.stage !== 3'd4 || bus.ctrl !== 15'h0EF3) begin
                    n_mis++;
                    $display("FAIL sta_t4: stage=%0d ctrl=%h, want 4 0ef3", bus.stage, bus.ctrl);
                end
            end
            tick();
            n_cmp++;
            if (bus.stage !== 3'd0 || bus.ctrl !== 15'h27E3) begin
                n_mis++;
                $display("FAIL op%h_end: stage=%0d ctrl=%h, want 0 27e3",
                         ops[k], bus.stage, bus.ctrl);
            end
        end
    endtask

    task automatic test_jz();
        logic        zf[2]   = '{1'b1, 1'b0};
        logic [14:0] want[2] = '{JZ_TAKEN, 15'h0FE3};
        bus.opcode = 4'h8;
        for (int k = 0; k < 2; k++) begin
            bus.zero_flag = zf[k];
            tick();
            tick();
            tick();
            n_cmp++;
            if (bus.stage !== 3'd3 || bus.ctrl !== want[k]) begin
                n_mis++;
                $display("FAIL jz_zf%0d: stage=%0d ctrl=%h, want 3 %h",
                         zf[k], bus.stage, bus.ctrl, want[k]);
            end
            tick();
            n_cmp++;
            if (bus.stage !== 3'd0) begin
                n_mis++;
                $display("FAIL jz_end: stage=%0d, want 0", bus.stage);
            end
        end
        bus.zero_flag = 1'b0;
    endtask

    // ADD stepped one stage per 4 cycles; opcode swapped to LDA during T4
    task automatic test_single_step();
        int unsigned es[6] = '{1, 2, 3, 4, 5, 0};
        logic [14:0] ec[6] = '{15'h4FE3, 15'h0D63, 15'h07A3, 15'h0DE1, 15'h0FC7, 15'h27E3};
        bus.opcode = 4'h2;
        for (int k = 0; k < 6; k++) begin
            bus.advance = 1'b1;
            tick();
            bus.advance = 1'b0;
            if (k == 3) bus.opcode = 4'h4;
            for (int j = 0; j < 4; j++) begin
                if (j > 0) tick();
                n_cmp++;
                if (bus.stage !== 3'(es[k]) || bus.ctrl !== ec[k]) begin
                    n_mis++;
                    $display("FAIL step[%0d.%0d]: stage=%0d ctrl=%h, want %0d %h",
                             k, j, bus.stage, bus.ctrl, es[k], ec[k]);
                end
            end
        end
        bus.advance = 1'b1;
    endtask

    task automatic test_reset_mid();
        bus.opcode = 4'h6;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (bus.stage !== 3'd6 || bus.ctrl !== 15'h0FE3 || bus.fetch !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_mid: stage=%0d ctrl=%h fetch=%b, want 6 0fe3 0",
                     bus.stage, bus.ctrl, bus.fetch);
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.stage !== 3'd0 || bus.ctrl !== 15'h27E3) begin
            n_mis++;
            $display("FAIL reset_mid_t0: stage=%0d ctrl=%h, want 0 27e3", bus.stage, bus.ctrl);
        end
    endtask

    task automatic test_halt();
        bus.opcode = 4'h0;
        tick();
        tick();
        tick();
        n_cmp++;
        if (bus.stage !== 3'd3 || bus.ctrl !== 15'h0FE3 || bus.halted !== 1'b0) begin
            n_mis++;
            $display("FAIL hlt_t3: stage=%0d ctrl=%h halted=%b, want 3 0fe3 0",
                     bus.stage, bus.ctrl, bus.halted);
        end
        bus.opcode = 4'h5;
        for (int i = 0; i < 20; i++) begin
            bus.advance = (i % 2 == 0);
            tick();
            n_cmp++;
            if (bus.stage !== 3'd7 || bus.ctrl !== 15'h0FE3 || bus.halted !== 1'b1) begin
                n_mis++;
                $display("FAIL halt[%0d]: stage=%0d ctrl=%h halted=%b, want 7 0fe3 1",
                         i, bus.stage, bus.ctrl, bus.halted);
            end
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (bus.stage !== 3'd6 || bus.halted !== 1'b0 || bus.ctrl !== 15'h0FE3) begin
            n_mis++;
            $display("FAIL halt_reset: stage=%0d halted=%b ctrl=%h, want 6 0 0fe3",
                     bus.stage, bus.halted, bus.ctrl);
        end
        rst_n       = 1'b1;
        bus.advance = 1'b1;
        tick();
        n_cmp++;
        if (bus.stage !== 3'd0 || bus.ctrl !== 15'h27E3) begin
            n_mis++;
            $display("FAIL halt_restart: stage=%0d ctrl=%h, want 0 27e3", bus.stage, bus.ctrl);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_lda();
        test_add_sub();
        test_short_ops();
        test_jz();
        test_single_step();
        test_reset_mid();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
